// File: rtl/otter_mem_resp_if.sv
// Bus bundle between the OTTER core and its memory/MMIO responder.
// Port 1 is the instruction fetch path. Port 2 is the load/store path.
// The IO_* signals form the memory-mapped I/O side.
interface otter_mem_resp_if;
  logic        MEM_RDEN1;
  logic [13:0] MEM_ADDR1;
  logic [31:0] MEM_DOUT1;
  logic        MEM_RDEN2;
  logic        MEM_WE2;
  logic [31:0] MEM_ADDR2;
  logic [31:0] MEM_DIN2;
  logic [1:0]  MEM_SIZE;
  logic        MEM_SIGN;
  logic [31:0] MEM_DOUT2;
  logic [31:0] IO_IN;
  logic        IO_WR;
  logic [31:0] IO_ADDR;
  logic [31:0] IO_DATA;
  logic        ERR_MISALIGN;

  // Core side: issues requests and consumes responses.
  modport master (
    output MEM_RDEN1, MEM_ADDR1, MEM_RDEN2, MEM_WE2, MEM_ADDR2, MEM_DIN2,
           MEM_SIZE, MEM_SIGN, IO_IN,
    input  MEM_DOUT1, MEM_DOUT2, IO_WR, IO_ADDR, IO_DATA, ERR_MISALIGN
  );

  // Memory side: services requests and produces responses.
  modport slave (
    input  MEM_RDEN1, MEM_ADDR1, MEM_RDEN2, MEM_WE2, MEM_ADDR2, MEM_DIN2,
           MEM_SIZE, MEM_SIGN, IO_IN,
    output MEM_DOUT1, MEM_DOUT2, IO_WR, IO_ADDR, IO_DATA, ERR_MISALIGN
  );
endinterface

// File: rtl/otter_mem_resp.sv
// OTTER dual-port memory with a byte-lane load/store responder and an MMIO window.
// Port 1 is a registered instruction read.
// Port 2 is sequenced by a small FSM: IDLE -> LOAD_RSP or STORE_RSP -> IDLE.
// DEPTH_WORDS must be a power of two so that address wrap is a plain truncation.
module otter_mem_resp #(
  parameter int          DEPTH_WORDS = 4096,
  parameter logic [31:0] IO_BASE     = 32'h1100_0000
) (
  input logic             CLK,
  input logic             RST,
  otter_mem_resp_if.slave bus
);

  localparam int AW = (DEPTH_WORDS > 1) ? $clog2(DEPTH_WORDS) : 1;

  typedef enum logic [1:0] {IDLE, LOAD_RSP, STORE_RSP} state_t;

  state_t      state, state_nxt;
  logic [31:0] ram [DEPTH_WORDS];

  logic [AW-1:0] idx1, idx2;
  logic          is_mmio, aligned, accept, do_store, do_load;
  logic [3:0]    wmask;
  logic [31:0]   wdata, io_wdata;

  assign idx1     = AW'(bus.MEM_ADDR1);
  assign idx2     = AW'(bus.MEM_ADDR2[31:2]);
  assign is_mmio  = (bus.MEM_ADDR2 >= IO_BASE);
  // A store wins over a load presented in the same cycle.
  assign accept   = (state == IDLE) && (bus.MEM_WE2 || bus.MEM_RDEN2);
  assign do_store = (state == IDLE) && bus.MEM_WE2;
  assign do_load  = (state == IDLE) && !bus.MEM_WE2 && bus.MEM_RDEN2;

  // Shift the addressed lane(s) down to bit 0 and extend.
  // zext=1 zero-extends; zext=0 sign-extends.
  function automatic logic [31:0] extend(input logic [31:0] raw, input logic [1:0] lane,
                                         input logic [1:0] size, input logic zext);
    logic [31:0] sh;
    sh = raw >> {lane, 3'b000};
    case (size)
      2'd0:    extend = zext ? {24'b0, sh[7:0]}  : {{24{sh[7]}},  sh[7:0]};
      2'd1:    extend = zext ? {16'b0, sh[15:0]} : {{16{sh[15]}}, sh[15:0]};
      default: extend = sh;
    endcase
  endfunction

  // Decode alignment, RAM byte-lane enables, and size-masked MMIO store data.
  always_comb begin
    // NOTE: every always_comb output gets a default first, so no path can infer a latch.
    aligned  = 1'b0;
    wmask    = 4'b0000;
    wdata    = bus.MEM_DIN2;
    io_wdata = bus.MEM_DIN2;
    case (bus.MEM_SIZE)
      2'd0: begin
        aligned  = 1'b1;
        wmask    = 4'b0001 << bus.MEM_ADDR2[1:0];
        wdata    = {4{bus.MEM_DIN2[7:0]}};
        io_wdata = {24'b0, bus.MEM_DIN2[7:0]};
      end
      2'd1: begin
        aligned  = !bus.MEM_ADDR2[0];
        wmask    = 4'b0011 << bus.MEM_ADDR2[1:0];
        wdata    = {2{bus.MEM_DIN2[15:0]}};
        io_wdata = {16'b0, bus.MEM_DIN2[15:0]};
      end
      2'd2: begin
        aligned  = (bus.MEM_ADDR2[1:0] == 2'b00);
        wmask    = 4'b1111;
      end
      default: aligned = 1'b0;
    endcase
  end

  // Port-2 FSM state register.
  always_ff @(posedge CLK) begin
    // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
    if (RST) state <= IDLE;
    else     state <= state_nxt;
  end

  // Port-2 FSM next state. Response states last one cycle and ignore new requests.
  always_comb begin
    state_nxt = IDLE;
    case (state)
      IDLE: begin
        if (bus.MEM_WE2)        state_nxt = STORE_RSP;
        else if (bus.MEM_RDEN2) state_nxt = LOAD_RSP;
        else                    state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  // RAM byte-lane write. Suppressed during reset, for MMIO, and for misaligned stores.
  always_ff @(posedge CLK) begin
    // NOTE: the RAM array has no reset branch; its contents survive RST, and a memory can't be cleared in one cycle.
    if (!RST && do_store && aligned && !is_mmio) begin
      for (int i = 0; i < 4; i++) begin
        if (wmask[i]) ram[idx2][8*i +: 8] <= wdata[8*i +: 8];
      end
    end
  end

  // Port-1 registered fetch. A same-cycle port-2 write is not yet visible here.
  always_ff @(posedge CLK) begin
    if (RST)                bus.MEM_DOUT1 <= '0;
    else if (bus.MEM_RDEN1) bus.MEM_DOUT1 <= ram[idx1];
  end

  // Port-2 response registers: load data, error pulse, and MMIO strobe/capture.
  always_ff @(posedge CLK) begin
    if (RST) begin
      bus.MEM_DOUT2    <= '0;
      bus.ERR_MISALIGN <= 1'b0;
      bus.IO_WR        <= 1'b0;
      bus.IO_ADDR      <= '0;
      bus.IO_DATA      <= '0;
    end else begin
      bus.ERR_MISALIGN <= accept && !aligned;
      bus.IO_WR        <= do_store && aligned && is_mmio;
      if (accept && !aligned)
        bus.MEM_DOUT2 <= '0;
      else if (do_load)
        bus.MEM_DOUT2 <= extend(is_mmio ? bus.IO_IN : ram[idx2], bus.MEM_ADDR2[1:0],
                                bus.MEM_SIZE, bus.MEM_SIGN);
      if (do_store && aligned && is_mmio) begin
        bus.IO_ADDR <= bus.MEM_ADDR2;
        bus.IO_DATA <= io_wdata;
      end
    end
  end

endmodule

// File: tb/tb_otter_mem_resp.sv
// Directed testbench for otter_mem_resp.
// Stimulus is driven 1 ns after each rising edge.
// Outputs are checked 1 ns after the edge that produces them.
module tb_otter_mem_resp;

  logic clk = 1'b0;
  logic rst = 1'b1;
  int   checks = 0;
  int   errors = 0;

  always #5 clk = ~clk;

  otter_mem_resp_if bus ();

  otter_mem_resp #(.DEPTH_WORDS(4096), .IO_BASE(32'h1100_0000)) dut (
    .CLK (clk),
    .RST (rst),
    .bus (bus)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp)
    else begin
      errors++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic clear_req();
    bus.MEM_RDEN1 = 1'b0;
    bus.MEM_RDEN2 = 1'b0;
    bus.MEM_WE2   = 1'b0;
  endtask

  task automatic drive2(input logic we, input logic rd, input logic [31:0] a,
                        input logic [31:0] d, input logic [1:0] sz, input logic sg);
    bus.MEM_WE2   = we;
    bus.MEM_RDEN2 = rd;
    bus.MEM_ADDR2 = a;
    bus.MEM_DIN2  = d;
    bus.MEM_SIZE  = sz;
    bus.MEM_SIGN  = sg;
  endtask

  // Issue one port-2 request and return #1 after the edge that enters the response state.
  task automatic store(input logic [31:0] a, input logic [31:0] d, input logic [1:0] sz);
    drive2(1'b1, 1'b0, a, d, sz, 1'b0);
    tick();
    clear_req();
  endtask

  task automatic load(input logic [31:0] a, input logic [1:0] sz, input logic sg);
    drive2(1'b0, 1'b1, a, 32'h0, sz, sg);
    tick();
    clear_req();
  endtask

  initial begin
    clear_req();
    bus.MEM_ADDR1 = '0;
    drive2(1'b0, 1'b0, 32'h0, 32'h0, 2'd2, 1'b0);
    bus.IO_IN = 32'h0;

    // Reset
    tick(); tick();
    rst = 1'b0;
    check("rst_dout1", bus.MEM_DOUT1, 32'h0);
    check("rst_dout2", bus.MEM_DOUT2, 32'h0);
    check("rst_io_wr", {31'b0, bus.IO_WR}, 32'h0);
    check("rst_io_addr", bus.IO_ADDR, 32'h0);
    check("rst_io_data", bus.IO_DATA, 32'h0);
    check("rst_err", {31'b0, bus.ERR_MISALIGN}, 32'h0);

    // Word store then word load, with a port-1 fetch of the same word
    store(32'h100, 32'hDEAD_BEEF, 2'd2);
    check("st_word_err", {31'b0, bus.ERR_MISALIGN}, 32'h0);
    check("st_word_iowr", {31'b0, bus.IO_WR}, 32'h0);
    tick();
    bus.MEM_RDEN1 = 1'b1;
    bus.MEM_ADDR1 = 14'h40;
    load(32'h100, 2'd2, 1'b0);
    check("ld_word", bus.MEM_DOUT2, 32'hDEAD_BEEF);
    check("fetch_word", bus.MEM_DOUT1, 32'hDEAD_BEEF);
    // A misaligned request during LOAD_RSP must be ignored.
    drive2(1'b0, 1'b1, 32'h101, 32'h0, 2'd2, 1'b0);
    tick();
    clear_req();
    check("rsp_ignore_err", {31'b0, bus.ERR_MISALIGN}, 32'h0);
    check("dout2_hold", bus.MEM_DOUT2, 32'hDEAD_BEEF);
    check("dout1_hold", bus.MEM_DOUT1, 32'hDEAD_BEEF);

    // Byte store into a zeroed word, then loads with both extensions
    store(32'h100, 32'h0, 2'd2);             tick();
    store(32'h103, 32'h1234_5680, 2'd0);     tick();
    load(32'h103, 2'd0, 1'b0);
    check("ld_byte_sext", bus.MEM_DOUT2, 32'hFFFF_FF80);
    tick();
    load(32'h103, 2'd0, 1'b1);
    check("ld_byte_zext", bus.MEM_DOUT2, 32'h0000_0080);
    tick();
    load(32'h100, 2'd2, 1'b0);
    check("ld_word_after_byte", bus.MEM_DOUT2, 32'h8000_0000);
    tick();

    // Misaligned half load and illegal-size store
    load(32'h101, 2'd1, 1'b0);
    check("mis_half_err", {31'b0, bus.ERR_MISALIGN}, 32'h1);
    check("mis_half_dout2", bus.MEM_DOUT2, 32'h0);
    tick();
    check("mis_half_err_end", {31'b0, bus.ERR_MISALIGN}, 32'h0);
    store(32'h102, 32'hFFFF_FFFF, 2'd3);
    check("ill_store_err", {31'b0, bus.ERR_MISALIGN}, 32'h1);
    tick();
    check("ill_store_err_end", {31'b0, bus.ERR_MISALIGN}, 32'h0);
    load(32'h100, 2'd2, 1'b0);
    check("ill_store_ram", bus.MEM_DOUT2, 32'h8000_0000);
    tick();

    // Half store into the upper lanes, then signed/unsigned half loads
    store(32'h102, 32'h0000_BEEF, 2'd1);     tick();
    load(32'h100, 2'd2, 1'b0);
    check("st_half_word", bus.MEM_DOUT2, 32'hBEEF_0000);
    tick();
    load(32'h102, 2'd1, 1'b0);
    check("ld_half_sext", bus.MEM_DOUT2, 32'hFFFF_BEEF);
    tick();
    load(32'h102, 2'd1, 1'b1);
    check("ld_half_zext", bus.MEM_DOUT2, 32'h0000_BEEF);
    tick();

    // Address wrap: word 0x1000 aliases word 0 in a 4096-word RAM
    store(32'h4000, 32'h55AA_55AA, 2'd2);    tick();
    load(32'h0, 2'd2, 1'b0);
    check("wrap", bus.MEM_DOUT2, 32'h55AA_55AA);
    tick();

    // MMIO store: strobe, capture, and RAM untouched (IO_BASE also aliases word 0)
    store(32'h1100_0000, 32'h0000_FFFF, 2'd2);
    check("io_wr_pulse", {31'b0, bus.IO_WR}, 32'h1);
    check("io_addr", bus.IO_ADDR, 32'h1100_0000);
    check("io_data", bus.IO_DATA, 32'h0000_FFFF);
    tick();
    check("io_wr_end", {31'b0, bus.IO_WR}, 32'h0);
    load(32'h0, 2'd2, 1'b0);
    check("io_ram_unchanged", bus.MEM_DOUT2, 32'h55AA_55AA);
    tick();
    store(32'h1100_0005, 32'hABCD_EF99, 2'd0);
    check("io_byte_addr", bus.IO_ADDR, 32'h1100_0005);
    check("io_byte_data", bus.IO_DATA, 32'h0000_0099);
    tick();

    // MMIO loads
    bus.IO_IN = 32'h1234_5678;
    load(32'h1100_0002, 2'd1, 1'b1);
    check("io_ld_half", bus.MEM_DOUT2, 32'h0000_1234);
    tick();
    bus.IO_IN = 32'h1234_56F8;
    load(32'h1100_0000, 2'd0, 1'b0);
    check("io_ld_byte_sext", bus.MEM_DOUT2, 32'hFFFF_FFF8);
    tick();

    // Store+load together under RST: nothing happens
    store(32'h200, 32'h1111_1111, 2'd2);     tick();
    rst = 1'b1;
    drive2(1'b1, 1'b1, 32'h200, 32'h7777_7777, 2'd2, 1'b0);
    tick();
    rst = 1'b0;
    clear_req();
    check("rst_req_dout1", bus.MEM_DOUT1, 32'h0);
    check("rst_req_dout2", bus.MEM_DOUT2, 32'h0);
    check("rst_req_iowr", {31'b0, bus.IO_WR}, 32'h0);
    check("rst_req_ioaddr", bus.IO_ADDR, 32'h0);
    check("rst_req_iodata", bus.IO_DATA, 32'h0);
    check("rst_req_err", {31'b0, bus.ERR_MISALIGN}, 32'h0);
    load(32'h200, 2'd2, 1'b0);
    check("rst_req_nowrite", bus.MEM_DOUT2, 32'h1111_1111);
    tick();

    // Same request without RST: store wins, load dropped, port 1 reads the old word
    bus.MEM_RDEN1 = 1'b1;
    bus.MEM_ADDR1 = 14'h80;
    drive2(1'b1, 1'b1, 32'h200, 32'h7777_7777, 2'd2, 1'b0);
    tick();
    clear_req();
    check("dual_dout2_hold", bus.MEM_DOUT2, 32'h1111_1111);
    check("dual_fetch_old", bus.MEM_DOUT1, 32'h1111_1111);
    check("dual_err", {31'b0, bus.ERR_MISALIGN}, 32'h0);
    tick();
    bus.MEM_RDEN1 = 1'b1;
    load(32'h200, 2'd2, 1'b0);
    check("dual_store_done", bus.MEM_DOUT2, 32'h7777_7777);
    check("dual_fetch_new", bus.MEM_DOUT1, 32'h7777_7777);
    tick();

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/otter_mem_resp.md
OTTER_MEM_RESP -- requirements
Module: otter_mem_resp

Interface
REQ-001 The block SHALL have parameter DEPTH_WORDS, default 4096, giving the number of 32-bit words of internal RAM.
REQ-002 The block SHALL have parameter IO_BASE, default 32'h1100_0000; port-2 byte addresses >= IO_BASE are MMIO, not RAM.
REQ-003 The block SHALL have port CLK  in  1  system clock; all state updates on rising edge.
REQ-004 The block SHALL have port RST  in  1  reset: synchronous, active-high.
REQ-005 The block SHALL have port MEM_RDEN1  in  1  instruction-fetch read enable.
REQ-006 The block SHALL have port MEM_ADDR1  in  14  instruction word address (PC[15:2]).
REQ-007 The block SHALL have port MEM_DOUT1  out  32  fetched instruction word.
REQ-008 The block SHALL have port MEM_RDEN2  in  1  data read enable (load).
REQ-009 The block SHALL have port MEM_WE2  in  1  data write enable (store).
REQ-010 The block SHALL have port MEM_ADDR2  in  32  data byte address.
REQ-011 The block SHALL have port MEM_DIN2  in  32  store data, right-justified.
REQ-012 The block SHALL have port MEM_SIZE  in  2  access size: 0 byte, 1 half, 2 word, 3 illegal.
REQ-013 The block SHALL have port MEM_SIGN  in  1  load zero-extend when 1, sign-extend when 0.
REQ-014 The block SHALL have port MEM_DOUT2  out  32  load data, extended to 32 bits.
REQ-015 The block SHALL have port IO_IN  in  32  MMIO read data, sampled on MMIO load.
REQ-016 The block SHALL have port IO_WR  out  1  one-cycle strobe on MMIO store.
REQ-017 The block SHALL have port IO_ADDR  out  32  captured MMIO byte address; IO_DATA  out  32  captured MMIO store data.
REQ-018 The block SHALL have port ERR_MISALIGN  out  1  one-cycle pulse on misaligned or illegal-size port-2 access.

Function
REQ-019 Port 1 SHALL be a registered read: MEM_RDEN1=1 at edge N makes MEM_DOUT1 = RAM[MEM_ADDR1] after edge N; MEM_RDEN1=0 holds MEM_DOUT1.
REQ-020 Port-2 accesses SHALL be handled by a three-state FSM: IDLE, LOAD_RSP, STORE_RSP.
REQ-021 In IDLE, MEM_WE2=1 SHALL move the FSM to STORE_RSP; otherwise MEM_RDEN2=1 SHALL move it to LOAD_RSP; otherwise it SHALL stay in IDLE.
REQ-022 When MEM_WE2 and MEM_RDEN2 are both 1, the store SHALL take priority and the load request SHALL be dropped.
REQ-023 LOAD_RSP and STORE_RSP SHALL each last exactly one cycle and return to IDLE; requests presented in these states SHALL be ignored.
REQ-024 Alignment SHALL be: byte any address; half ADDR2[0]=0; word ADDR2[1:0]=0; MEM_SIZE=3 always illegal.
REQ-025 A misaligned or illegal access SHALL write nothing, assert no IO_WR, force MEM_DOUT2=0, and pulse ERR_MISALIGN for one cycle in the response state.
REQ-026 An aligned RAM store SHALL update only the addressed byte lanes (byte: 1 lane, half: 2 lanes, word: 4) at the edge that enters STORE_RSP.
REQ-027 An aligned RAM load SHALL register MEM_DOUT2 at the edge entering LOAD_RSP: selected lane(s) shifted to bit 0, zero- or sign-extended per MEM_SIGN; word loads ignore MEM_SIGN.
REQ-028 RAM index SHALL be ADDR2[31:2] modulo DEPTH_WORDS for addresses below IO_BASE, so addresses wrap.
REQ-029 An MMIO store SHALL leave RAM unchanged, capture IO_ADDR and IO_DATA (size-masked MEM_DIN2), and pulse IO_WR for one cycle in STORE_RSP.
REQ-030 An MMIO load SHALL set MEM_DOUT2 = IO_IN, extended per MEM_SIZE and MEM_SIGN from byte lane ADDR2[1:0].
REQ-031 When port 1 reads the same word port 2 writes in the same cycle, MEM_DOUT1 SHALL return the old (pre-write) data.
REQ-032 MEM_DOUT2 SHALL hold its value outside LOAD_RSP until the next load.

Reset
REQ-033 RST=1 at an edge SHALL force the FSM to IDLE and set MEM_DOUT1, MEM_DOUT2, IO_ADDR and IO_DATA to 0, and IO_WR and ERR_MISALIGN to 0, overriding any request at that edge.
REQ-034 RST SHALL NOT clear RAM contents, and a store requested in the same cycle as RST SHALL NOT be performed.
REQ-035 A response state interrupted by RST SHALL be abandoned with no strobe or error emitted.

Verification
REQ-036 Word store 0xDEADBEEF @0x100, then load word @0x100 -> MEM_DOUT2=0xDEADBEEF one edge after the load request.
REQ-037 Byte store 0x80 @0x103 over 0x00000000, then signed byte load @0x103 -> 0xFFFFFF80; unsigned -> 0x00000080; word @0x100 -> 0x80000000.
REQ-038 Half load @0x101 -> ERR_MISALIGN pulse for 1 cycle, MEM_DOUT2=0; half store @0x102 with MEM_SIZE=3 -> RAM unchanged, ERR_MISALIGN pulses.
REQ-039 Word store 0x0000FFFF @0x1100_0000 -> IO_WR for 1 cycle, IO_ADDR=0x1100_0000, IO_DATA=0x0000FFFF, RAM unchanged; IO_IN=0x12345678 with unsigned half load @0x1100_0002 -> 0x00001234.
REQ-040 MEM_WE2=1 and MEM_RDEN2=1 together, with RST asserted in that same cycle -> no write, FSM IDLE, all outputs 0; repeat without RST -> store only, MEM_DOUT2 unchanged.
